// File: rtl/count_framer_cw16.sv
// count_framer_cw16
// Wraps a stream of counted payload words into frames: each frame begins with
// one header word {frame_seq, cnt_limit} and then passes the payload words
// through unchanged. tlast follows s_axis_final_cnt. The in-frame index
// s_axis_count is compared against the expected index. A mismatch raises a
// one-cycle seq_err pulse and sets err_sticky. After a mismatch the expected
// index resynchronises to the received count.
//
// Ports:
//   clk               single clock, rising edge
//   sync_reset        synchronous active-high reset
//   s_axis_tvalid     upstream word valid
//   s_axis_tdata      upstream payload word
//   s_axis_final_cnt  last word of the frame (sampled with tdata)
//   s_axis_count      in-frame word index (sampled with tdata)
//   s_axis_tready     block accepts the upstream word
//   cnt_limit         frame length minus one, captured into the header
//   m_axis_tvalid     output word valid
//   m_axis_tdata      header or payload word
//   m_axis_tlast      last word of the output frame
//   m_axis_tready     downstream accepts the word
//   seq_err           one-cycle pulse on a count discontinuity
//   err_sticky        latched seq_err, cleared only by reset
//   frame_seq         sequence number of the next header to emit
module count_framer_cw16 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_final_cnt,
    input  logic [15:0]           s_axis_count,
    output logic                  s_axis_tready,
    input  logic [15:0]           cnt_limit,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  seq_err,
    output logic                  err_sticky,
    output logic [15:0]           frame_seq
);

    typedef enum logic [0:0] {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    m_valid_r;
    logic [DATA_WIDTH-1:0]   m_data_r;
    logic                    m_last_r;
    logic [15:0]             frame_seq_r;
    logic [15:0]             exp_cnt_r;
    logic                    seq_err_r;
    logic                    err_sticky_r;

    logic                    out_free_s;
    logic                    tready_s;
    logic                    hdr_load_s;
    logic                    pay_acc_s;
    logic                    cnt_bad_s;

    // The header occupies the low 32 bits. Any wider payload bits are zero.
    function automatic logic [DATA_WIDTH-1:0] make_header(input logic [15:0] seq,
                                                          input logic [15:0] lim);
        logic [DATA_WIDTH-1:0] hdr;
        hdr         = {DATA_WIDTH{1'b0}};
        hdr[31:16]  = seq;
        hdr[15:0]   = lim;
        return hdr;
    endfunction

    // Handshake qualification and next-state selection.
    // Reset blocks every load so that nothing is accepted upstream while it is high.
    always_comb begin
        out_free_s  = !m_valid_r || m_axis_tready;
        state_nxt_s = state_r;
        tready_s    = 1'b0;
        hdr_load_s  = 1'b0;
        pay_acc_s   = 1'b0;
        case (state_r)
            ST_HDR: begin
                // The header waits for the first payload word to be presented
                // but does not consume it.
                if (s_axis_tvalid && out_free_s && !sync_reset) begin
                    hdr_load_s  = 1'b1;
                    state_nxt_s = ST_PAY;
                end else begin
                    hdr_load_s  = 1'b0;
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAY: begin
                tready_s  = out_free_s && !sync_reset;
                pay_acc_s = s_axis_tvalid && tready_s;
                if (pay_acc_s && s_axis_final_cnt) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_PAY;
                end
            end
            default: begin
                state_nxt_s = ST_HDR;
            end
        endcase
    end

    assign cnt_bad_s = pay_acc_s && (s_axis_count != exp_cnt_r);

    // State register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Single output stage.
    // A load takes priority over consumption, so a word taken in the same
    // cycle as a new load is replaced rather than dropped.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
            m_last_r  <= 1'b0;
        end else if (hdr_load_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= make_header(frame_seq_r, cnt_limit);
            m_last_r  <= 1'b0;
        end else if (pay_acc_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_axis_tdata;
            m_last_r  <= s_axis_final_cnt;
        end else if (m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    // Frame sequence, expected index and error flags.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            frame_seq_r  <= 16'h0000;
            exp_cnt_r    <= 16'h0000;
            seq_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            seq_err_r <= cnt_bad_s;
            if (cnt_bad_s) begin
                err_sticky_r <= 1'b1;
            end
            if (hdr_load_s) begin
                exp_cnt_r <= 16'h0000;
            end else if (pay_acc_s) begin
                // Resynchronise to the received index, even after a mismatch,
                // so that a single gap produces exactly one pulse.
                exp_cnt_r <= s_axis_count + 16'd1;
            end
            if (pay_acc_s && s_axis_final_cnt) begin
                frame_seq_r <= frame_seq_r + 16'd1;
            end
        end
    end

    assign s_axis_tready = tready_s;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_tlast  = m_last_r;
    assign seq_err       = seq_err_r;
    assign err_sticky    = err_sticky_r;
    assign frame_seq     = frame_seq_r;

endmodule

// File: doc/count_framer_cw16.md
COUNT_FRAMER_CW16 -- requirements
Module: count_framer_cw16

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, payload word width; legal values are >= 32.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port sync_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port s_axis_tvalid  input  1  upstream word valid.
REQ-005 SHALL provide port s_axis_tdata  input  DATA_WIDTH  upstream payload word.
REQ-006 SHALL provide port s_axis_final_cnt  input  1  marks last word of a frame; sampled with tdata.
REQ-007 SHALL provide port s_axis_count  input  16  in-frame word index; sampled with tdata.
REQ-008 SHALL provide port s_axis_tready  output  1  block accepts upstream word.
REQ-009 SHALL provide port cnt_limit  input  16  frame length minus one; sampled at header load.
REQ-010 SHALL provide port m_axis_tvalid  output  1  output word valid.
REQ-011 SHALL provide port m_axis_tdata  output  DATA_WIDTH  header or payload word.
REQ-012 SHALL provide port m_axis_tlast  output  1  last word of output frame.
REQ-013 SHALL provide port m_axis_tready  input  1  downstream accepts word.
REQ-014 SHALL provide port seq_err  output  1  one-cycle pulse on count discontinuity.
REQ-015 SHALL provide port err_sticky  output  1  latched seq_err, cleared only by reset.
REQ-016 SHALL provide port frame_seq  output  16  sequence number of the next header to emit.

Function
REQ-017 SHALL implement states HDR and PAY; HDR is entered on reset and after each tlast word is loaded.
REQ-018 SHALL hold the output in a single register stage (valid + data + tlast); "out_free" = !m_axis_tvalid | m_axis_tready.
REQ-019 In HDR, SHALL drive s_axis_tready = 0.
REQ-019a In HDR, when s_axis_tvalid & out_free, SHALL load the header word into the output register and enter PAY next cycle.
REQ-020 Header word SHALL be: bits[31:16] = frame_seq, bits[15:0] = cnt_limit, bits above 31 = 0; header tlast = 0.
REQ-021 In PAY, SHALL drive s_axis_tready = out_free.
REQ-021a In PAY, each accepted word (tvalid & tready) SHALL be loaded as {tdata, tlast = s_axis_final_cnt}.
REQ-022 Latency SHALL be exactly 1 cycle from input handshake to m_axis_tvalid; no combinational path from s_axis_* to m_axis_*.
REQ-023 When m_axis_tready = 0 and m_axis_tvalid = 1, the output register SHALL hold its data, tlast and valid unchanged.
REQ-024 Output register SHALL clear valid when consumed and no new word/header is loaded in the same cycle.
REQ-024a Back-to-back throughput in PAY SHALL be 1 word/cycle.
REQ-025 On accepting a word with s_axis_final_cnt = 1, SHALL increment frame_seq (0xFFFF wraps to 0x0000) and enter HDR next cycle.
REQ-026 SHALL maintain expected index exp_cnt (16 bit), set to 0 on header load.
REQ-026a On each accepted payload word, if s_axis_count != exp_cnt, SHALL pulse seq_err for one cycle.
REQ-026b On each accepted payload word, exp_cnt SHALL be set to s_axis_count + 1 (resync, mod 2^16).
REQ-027 seq_err SHALL assert on the cycle after the offending handshake.
REQ-027a err_sticky SHALL set in the same cycle as seq_err.
REQ-028 A frame of N payload words SHALL produce N+1 output words, with tlast on the final one only.
REQ-029 A single-word frame (final_cnt on first word) SHALL emit header + 1 word with tlast.
REQ-029a After a single-word frame, the block SHALL return to HDR.
REQ-030 If out_free and a load coincide with downstream consumption, the load SHALL win; no word is dropped or duplicated.

Reset
REQ-031 sync_reset SHALL force, on the next edge, regardless of state:
- state = HDR
- m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0
- frame_seq = 0, exp_cnt = 0
- seq_err = 0, err_sticky = 0
REQ-032 While sync_reset is high, s_axis_tready SHALL be 0.
REQ-033 Reset mid-frame SHALL discard the output register contents; the first frame after reset starts with header frame_seq = 0.

Verification
REQ-034 cnt_limit = 3, 4 words with count 0..3, final on 3, tready = 1 -> 5 outputs: 0x00000003, d0..d3; tlast on d3; frame_seq becomes 1.
REQ-035 Two back-to-back frames with cnt_limit = 0 -> headers 0x00000000 then 0x00010000, each followed by one tlast word; zero idle cycles in PAY.
REQ-036 m_axis_tready toggling 1010... during a 4-word frame -> output sequence identical to REQ-034; each word held stable while stalled.
REQ-037 counts 0,1,3,4 -> seq_err pulses once (cycle after the count = 3 word); err_sticky = 1; no further pulses.
REQ-038 Force frame_seq 0xFFFF, run one frame -> header shows 0xFFFF; frame_seq wraps to 0x0000.
REQ-039 sync_reset asserted after header + 2 payload words -> m_axis_tvalid = 0 next cycle; next frame header = 0x0000xxxx with exp_cnt reset.
